// File: rtl/spi_sample_packer.sv
// spi_sample_packer
//   Packs pairs of bytes from the SPI flash read path into 16-bit signed PCM
//   samples and buffers them in a first-word-fall-through FIFO for the I2S side.
//
//   Ports
//     clk, rst        system clock, synchronous active-high reset
//     flush           synchronous clear of assembly state, FIFO and overflow
//     byte_in/valid   incoming byte and one-cycle strobe
//     byte_ready      FIFO has room (based on registered level)
//     sample_out      FIFO head (16'h0000 while empty)
//     sample_valid    FIFO not empty
//     sample_ready    consumer takes head when sample_valid is high
//     fifo_level      occupied entries, 0..FIFO_DEPTH
//     overflow        sticky: a complete sample was dropped
//
//   Configuration macro
//     SPI_SAMPLE_PACKER_BIG_ENDIAN_EN  defined   -> sample = {first, second}
//                                      undefined -> sample = {second, first} (WAV)
module spi_sample_packer #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [7:0]                    byte_in,
   input  logic                          byte_valid,
   output logic                          byte_ready,
   output logic [15:0]                   sample_out,
   output logic                          sample_valid,
   input  logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {S_FIRST, S_SECOND} state_t;

   state_t        r_state, w_state_nxt;
   logic [7:0]    r_hold;
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wptr, r_rptr;
   logic          r_ovf;

   logic [AW:0]   w_level;
   logic          w_full, w_empty;
   logic          w_push_req, w_push, w_pop;
   logic [15:0]   w_sample;

   // Extra pointer bit distinguishes full from empty; the difference is the level.
   assign w_level = r_wptr - r_rptr;
   assign w_full  = (w_level == (AW+1)'(FIFO_DEPTH));
   assign w_empty = (r_wptr == r_rptr);

`ifdef SPI_SAMPLE_PACKER_BIG_ENDIAN_EN
   assign w_sample = {r_hold, byte_in};
`else
   assign w_sample = {byte_in, r_hold};
`endif

   // Room is judged on the registered level only; a same-cycle pop does not help.
   assign w_push = w_push_req & ~w_full;
   assign w_pop  = ~w_empty & sample_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) r_state <= S_FIRST;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push_req  = 1'b0;
      case (r_state)
         S_FIRST:  if (byte_valid) w_state_nxt = S_SECOND;
         S_SECOND: if (byte_valid) begin
            w_push_req  = 1'b1;
            w_state_nxt = S_FIRST;   // returns even if the push is rejected
         end
         default:  w_state_nxt = S_FIRST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_hold <= 8'h00;
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (r_state == S_FIRST && byte_valid) r_hold <= byte_in;
         if (w_push)                           r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)                            r_rptr <= r_rptr + (AW+1)'(1);
         if (w_push_req && w_full)             r_ovf  <= 1'b1;
      end
   end

   // Storage is not reset; its contents are only visible through the empty mask.
   always_ff @(posedge clk) begin
      if (!rst && !flush && w_push) r_mem[r_wptr[AW-1:0]] <= w_sample;
   end

   assign sample_valid = ~w_empty;
   assign sample_out   = w_empty ? 16'h0000 : r_mem[r_rptr[AW-1:0]];
   assign fifo_level   = w_level;
   assign byte_ready   = ~w_full;
   assign overflow     = r_ovf;

endmodule

// File: tb/tb_spi_sample_packer.sv
module tb_spi_sample_packer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1, flush = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0, sample_ready = 1'b0;
   logic        byte_ready, sample_valid, overflow;
   logic [15:0] sample_out;
   logic [3:0]  fifo_level;

   int errs = 0, checks = 0;

   // reference model: queue of samples, pending first byte, sticky flag
   logic [15:0] mq[$];
   bit          m_half;
   logic [7:0]  m_first;
   bit          m_ovf;

   spi_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .sample_out(sample_out), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .fifo_level(fifo_level), .overflow(overflow));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack(input logic [7:0] f, input logic [7:0] s);
`ifdef SPI_SAMPLE_PACKER_BIG_ENDIAN_EN
      return {f, s};
`else
      return {s, f};
`endif
   endfunction

   function automatic logic [7:0] first_of(input logic [15:0] v);
`ifdef SPI_SAMPLE_PACKER_BIG_ENDIAN_EN
      return v[15:8];
`else
      return v[7:0];
`endif
   endfunction

   function automatic logic [7:0] second_of(input logic [15:0] v);
`ifdef SPI_SAMPLE_PACKER_BIG_ENDIAN_EN
      return v[7:0];
`else
      return v[15:8];
`endif
   endfunction

   task automatic model_step();
      bit pop, full;
      if (rst || flush) begin
         mq.delete(); m_half = 0; m_first = 8'h00; m_ovf = 0;
         return;
      end
      pop  = (mq.size() > 0) && sample_ready;
      full = (mq.size() >= DEPTH);
      if (pop) void'(mq.pop_front());
      if (byte_valid) begin
         if (!m_half) begin
            m_first = byte_in; m_half = 1;
         end else begin
            m_half = 0;
            if (full) m_ovf = 1;
            else      mq.push_back(pack(m_first, byte_in));
         end
      end
   endtask

   task automatic check_all();
      chk("sample_valid", 32'(sample_valid), 32'(mq.size() > 0));
      chk("sample_out",   32'(sample_out),   32'(mq.size() > 0 ? mq[0] : 16'h0000));
      chk("fifo_level",   32'(fifo_level),   32'(mq.size()));
      chk("byte_ready",   32'(byte_ready),   32'(mq.size() < DEPTH));
      chk("overflow",     32'(overflow),     32'(m_ovf));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input bit bv, input logic [7:0] b, input bit sr, input bit fl, input bit r);
      byte_valid = bv; byte_in = b; sample_ready = sr; flush = fl; rst = r;
      cycle();
   endtask

   task automatic send(input logic [15:0] v, input bit sr);
      drive(1, first_of(v), sr, 0, 0);
      drive(1, second_of(v), sr, 0, 0);
   endtask

   initial begin
      // reset state
      drive(0, 8'h00, 0, 0, 1);
      chk("rst_ready", 32'(byte_ready), 32'd1);
      chk("rst_out",   32'(sample_out), 32'h0);
      drive(0, 8'h00, 0, 0, 0);

      // bytes 34,12 -> single sample visible next cycle
      drive(1, 8'h34, 0, 0, 0);
      drive(1, 8'h12, 0, 0, 0);
`ifdef SPI_SAMPLE_PACKER_BIG_ENDIAN_EN
      chk("order_be", 32'(sample_out), 32'h3412);
`else
      chk("order_le", 32'(sample_out), 32'h1234);
`endif
      chk("order_lvl", 32'(fifo_level), 32'd1);

      // fill past capacity
      drive(0, 8'h00, 0, 1, 0);
      for (int k = 1; k <= 9; k++) begin
         send(16'(k), 0);
         if (k == 8) chk("full_ready", 32'(byte_ready), 32'd0);
      end
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_lvl", 32'(fifo_level), 32'd8);
      for (int k = 1; k <= 8; k++) begin
         byte_valid = 0; sample_ready = 1; flush = 0;
         chk("drain", 32'(sample_out), 32'(k));
         cycle();
      end
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // simultaneous push and pop at level 3
      drive(0, 8'h00, 0, 1, 0);
      send(16'h00A1, 0); send(16'h00A2, 0); send(16'h00A3, 0);
      drive(1, first_of(16'h00A4), 0, 0, 0);
      chk("pp_head", 32'(sample_out), 32'h00A1);
      drive(1, second_of(16'h00A4), 1, 0, 0);
      chk("pp_lvl", 32'(fifo_level), 32'd3);
      chk("pp_h2", 32'(sample_out), 32'h00A2);
      drive(0, 8'h00, 1, 0, 0);
      drive(0, 8'h00, 1, 0, 0);
      chk("pp_last", 32'(sample_out), 32'h00A4);
      drive(0, 8'h00, 1, 0, 0);

      // flush discards a partial byte
      drive(1, 8'hAA, 0, 0, 0);
      drive(0, 8'h00, 0, 1, 0);
      drive(1, 8'h01, 0, 0, 0);
      drive(1, 8'h02, 0, 0, 0);
      chk("fl_samp", 32'(sample_out), 32'(pack(8'h01, 8'h02)));
      chk("fl_ovf", 32'(overflow), 32'd0);
      chk("fl_lvl", 32'(fifo_level), 32'd1);

      // reset at level 5 mid-sample
      drive(0, 8'h00, 0, 1, 0);
      for (int k = 0; k < 5; k++) send(16'h1100 + 16'(k), 0);
      drive(1, 8'h77, 0, 0, 0);
      drive(1, 8'h55, 1, 1, 1);
      chk("rs_lvl", 32'(fifo_level), 32'd0);
      chk("rs_vld", 32'(sample_valid), 32'd0);
      chk("rs_out", 32'(sample_out), 32'h0);
      chk("rs_rdy", 32'(byte_ready), 32'd1);
      send(16'hBEEF, 0);
      chk("rs_next", 32'(sample_out), 32'hBEEF);

      // randomized traffic in phases of different consumer rates
      for (int ph = 0; ph < 12; ph++) begin
         int rp;
         rp = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 50 : 90;
         for (int c = 0; c < 200; c++) begin
            drive($urandom_range(99, 0) < 60, 8'($urandom), $urandom_range(99, 0) < rp,
                  $urandom_range(199, 0) == 0, $urandom_range(499, 0) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
